// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: controller state encoding and counter sizing.
package lc3b_types;

   typedef enum logic [1:0] {
      CTRL_RUN           = 2'd0,
      CTRL_MEM_WAIT      = 2'd1,
      CTRL_REDIRECT_WAIT = 2'd2
   } lc3b_ctrl_state;

   localparam int CTRL_CNT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; only reset brings it back to zero.
module sat_counter #(
   parameter int width = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc,
   output logic [width-1:0] count
);

   localparam logic [width-1:0] ONE = {{(width-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + ONE;
      end
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and redirect controller for the five-stage LC-3b pipeline: stage
// load/flush gating, WB-resolved redirects and performance counters.
module pipeline_ctrl
   import lc3b_types::*;
#(
   parameter int CNT_W = CTRL_CNT_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             icache_resp,
   input  logic             icache_busy,
   input  logic             dmem_req,
   input  logic             dcache_resp,
   input  logic             ld_use,
   input  logic             wb_valid,
   input  logic             branch_enable,
   input  logic             wb_indirect,
   input  logic [15:0]      redirect_addr,
   output logic             load_pc,
   output logic             load_if_id,
   output logic             load_id_ex,
   output logic             load_ex_mem,
   output logic             load_mem_wb,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             flush_ex_mem,
   output logic             flush_mem_wb,
   output logic             pc_redirect,
   output logic [15:0]      pc_target,
   output logic             dmem_inhibit,
   output logic [1:0]       ctrl_state,
   output logic [CNT_W-1:0] mispredict_count,
   output logic [CNT_W-1:0] stall_count
);

   lc3b_ctrl_state state, next_state;
   logic [15:0]    target_q;
   logic           redirect;
   logic           mem_stall;
   logic           fetch_hold;
   logic           latch_target;
   logic           mispredict_inc;

   assign redirect   = wb_valid & (branch_enable | wb_indirect);
   assign mem_stall  = dmem_req & ~dcache_resp;
   assign fetch_hold = ~icache_resp | ld_use;
   assign ctrl_state = state;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= CTRL_RUN;
      end else begin
         state <= next_state;
      end
   end

   // A redirect that cannot go out yet because a fetch is still in flight
   // parks its target here until the icache answers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         target_q <= 16'h0000;
      end else if (latch_target) begin
         target_q <= redirect_addr;
      end
   end

   always_comb begin
      next_state     = state;
      load_pc        = 1'b0;
      load_if_id     = 1'b0;
      load_id_ex     = 1'b0;
      load_ex_mem    = 1'b0;
      load_mem_wb    = 1'b0;
      flush_if_id    = 1'b0;
      flush_id_ex    = 1'b0;
      flush_ex_mem   = 1'b0;
      flush_mem_wb   = 1'b0;
      pc_redirect    = 1'b0;
      pc_target      = redirect_addr;
      dmem_inhibit   = 1'b0;
      latch_target   = 1'b0;
      mispredict_inc = 1'b0;

      unique case (state)
         CTRL_RUN: begin
            if (redirect) begin
               // The MEM instruction is wrong-path, so its access is killed
               // even when it would otherwise stall the pipe.
               dmem_inhibit   = 1'b1;
               flush_if_id    = 1'b1;
               flush_id_ex    = 1'b1;
               flush_ex_mem   = 1'b1;
               flush_mem_wb   = 1'b1;
               load_if_id     = 1'b1;
               load_id_ex     = 1'b1;
               load_ex_mem    = 1'b1;
               load_mem_wb    = 1'b1;
               mispredict_inc = 1'b1;
               if (icache_busy && !icache_resp) begin
                  latch_target = 1'b1;
                  next_state   = CTRL_REDIRECT_WAIT;
               end else begin
                  load_pc     = 1'b1;
                  pc_redirect = 1'b1;
               end
            end else if (mem_stall) begin
               load_mem_wb  = 1'b1;
               flush_mem_wb = 1'b1;
               next_state   = CTRL_MEM_WAIT;
            end else begin
               load_pc     = ~fetch_hold;
               load_if_id  = ~fetch_hold;
               load_id_ex  = 1'b1;
               load_ex_mem = 1'b1;
               load_mem_wb = 1'b1;
               flush_id_ex = fetch_hold;
            end
         end

         CTRL_MEM_WAIT: begin
            if (dcache_resp) begin
               load_pc     = ~fetch_hold;
               load_if_id  = ~fetch_hold;
               load_id_ex  = 1'b1;
               load_ex_mem = 1'b1;
               load_mem_wb = 1'b1;
               flush_id_ex = fetch_hold;
               next_state  = CTRL_RUN;
            end else begin
               load_mem_wb  = 1'b1;
               flush_mem_wb = 1'b1;
            end
         end

         CTRL_REDIRECT_WAIT: begin
            pc_target    = target_q;
            dmem_inhibit = 1'b1;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
            flush_mem_wb = 1'b1;
            load_if_id   = 1'b1;
            load_id_ex   = 1'b1;
            load_ex_mem  = 1'b1;
            load_mem_wb  = 1'b1;
            if (icache_resp) begin
               load_pc     = 1'b1;
               pc_redirect = 1'b1;
               next_state  = CTRL_RUN;
            end
         end

         default: begin
            next_state = CTRL_RUN;
         end
      endcase

      // Reset forces a safe, fully-flushed pipeline independent of the clock.
      if (!reset_n) begin
         next_state     = CTRL_RUN;
         load_pc        = 1'b0;
         load_if_id     = 1'b0;
         load_id_ex     = 1'b0;
         load_ex_mem    = 1'b0;
         load_mem_wb    = 1'b0;
         flush_if_id    = 1'b1;
         flush_id_ex    = 1'b1;
         flush_ex_mem   = 1'b1;
         flush_mem_wb   = 1'b1;
         pc_redirect    = 1'b0;
         pc_target      = 16'h0000;
         dmem_inhibit   = 1'b1;
         latch_target   = 1'b0;
         mispredict_inc = 1'b0;
      end
   end

   sat_counter #(.width(CNT_W)) u_mispredict_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (mispredict_inc),
      .count   (mispredict_count)
   );

   sat_counter #(.width(CNT_W)) u_stall_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (~load_pc),
      .count   (stall_count)
   );

endmodule
